// File: rtl/mode_sel_fsm.sv
// N-way mode selector: debounced press steps a mode index up/down with wrap or
// saturation, plus a synchronous load and a one-cycle step pulse.
module mode_sel_fsm #(
    parameter  int N_MODES    = 4,
    parameter  int DEB_CYCLES = 4,
    parameter  int WRAP       = 1,
    localparam int MODE_W     = (N_MODES > 2) ? $clog2(N_MODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              dir,
    input  logic              load,
    input  logic [MODE_W-1:0] load_val,
    output logic [MODE_W-1:0] mode,
    output logic [N_MODES-1:0] sel_out,
    output logic              step_out
);

    typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} deb_t;

    localparam logic [7:0]      CNT_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [MODE_W:0] TOP      = (MODE_W+1)'(N_MODES - 1);
    localparam logic [MODE_W:0] LIMIT    = (MODE_W+1)'(N_MODES);

    deb_t              state;
    logic [7:0]        cnt;
    logic              accept;
    logic              load_ok;
    logic [MODE_W:0]   mode_x;
    logic [MODE_W:0]   step_val;
    logic [MODE_W-1:0] mode_nxt;
    logic              step_nxt;

    always_comb begin
        accept = 1'b0;
        case (state)
            LOW:     accept = in && (DEB_CYCLES == 1);
            RISE:    accept = in && (cnt == CNT_LAST);
            default: accept = 1'b0;
        endcase

        // Extra headroom bit keeps the +1 from aliasing back into range for
        // non-power-of-two N_MODES before the end-of-range compare.
        mode_x = {1'b0, mode};
        if (!dir) begin
            if (mode_x == TOP) step_val = (WRAP != 0) ? '0 : mode_x;
            else               step_val = mode_x + 1'b1;
        end else begin
            if (mode_x == '0)  step_val = (WRAP != 0) ? TOP : mode_x;
            else               step_val = mode_x - 1'b1;
        end

        load_ok  = load && ({1'b0, load_val} < LIMIT);
        mode_nxt = mode;
        step_nxt = 1'b0;
        // Any load strobe consumes a coincident press, even an ignored one.
        if (load_ok) begin
            mode_nxt = load_val;
        end else if (accept && !load) begin
            mode_nxt = step_val[MODE_W-1:0];
            step_nxt = (step_val != mode_x);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= LOW;
            cnt      <= '0;
            mode     <= '0;
            sel_out  <= N_MODES'(1);
            step_out <= 1'b0;
        end else begin
            case (state)
                LOW: if (in) begin
                    if (DEB_CYCLES == 1) state <= HIGH;
                    else begin
                        state <= RISE;
                        cnt   <= 8'd1;
                    end
                end
                RISE: begin
                    if (!in) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: if (!in) begin
                    if (DEB_CYCLES == 1) state <= LOW;
                    else begin
                        state <= FALL;
                        cnt   <= 8'd1;
                    end
                end
                FALL: begin
                    if (in) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
            mode     <= mode_nxt;
            sel_out  <= N_MODES'(1) << mode_nxt;
            step_out <= step_nxt;
        end
    end

endmodule

// File: tb/tb_mode_sel_fsm.sv
// Directed bench for mode_sel_fsm: a 4-mode wrapping unit and a 5-mode
// saturating unit share the press input; step pulses are scoreboarded.
module tb_mode_sel_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       dir;
    logic       ld_a, ld_b;
    logic [1:0] lv_a;
    logic [2:0] lv_b;
    logic [1:0] mode_a;
    logic [2:0] mode_b;
    logic [3:0] sel_a;
    logic [4:0] sel_b;
    logic       step_a, step_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_a = 0;
    int cur_b = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    mode_sel_fsm #(.N_MODES(4), .DEB_CYCLES(4), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .in(din), .dir(dir), .load(ld_a), .load_val(lv_a),
        .mode(mode_a), .sel_out(sel_a), .step_out(step_a)
    );

    mode_sel_fsm #(.N_MODES(5), .DEB_CYCLES(4), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .in(din), .dir(dir), .load(ld_b), .load_val(lv_b),
        .mode(mode_b), .sel_out(sel_b), .step_out(step_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Every step pulse must match a queued expectation; a stray pulse fails.
    always @(negedge clk) begin
        logic [31:0] e;
        if (step_a === 1'b1) begin
            if (qa.size() == 0) chk("a_stray_step", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_step_mode", 32'(mode_a), e);
                chk("a_step_sel", 32'(sel_a), 32'd1 << e);
            end
        end
        if (step_b === 1'b1) begin
            if (qb.size() == 0) chk("b_stray_step", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_step_mode", 32'(mode_b), e);
                chk("b_step_sel", 32'(sel_b), 32'd1 << e);
            end
        end
    end

    // One press: 6 cycles high, optional 0-1 bounce, 6 cycles low.
    task automatic press(input int ea, input bit pa, input int eb, input bit pb,
                         input bit bounce, input bit ldb, input int lvb);
        din = 1'b1;
        repeat (3) tick();
        chk("a_pre_accept", 32'(mode_a), cur_a);
        chk("b_pre_accept", 32'(mode_b), cur_b);
        if (ldb) begin
            ld_b = 1'b1;
            lv_b = 3'(lvb);
        end
        if (pa) qa.push_back(ea);
        if (pb) qb.push_back(eb);
        tick();
        ld_b = 1'b0;
        chk("a_accept_mode", 32'(mode_a), ea);
        chk("a_accept_sel", 32'(sel_a), 32'd1 << ea);
        chk("a_accept_step", 32'(step_a), 32'(pa));
        chk("b_accept_mode", 32'(mode_b), eb);
        chk("b_accept_sel", 32'(sel_b), 32'd1 << eb);
        chk("b_accept_step", 32'(step_b), 32'(pb));
        cur_a = ea;
        cur_b = eb;
        repeat (2) tick();
        if (bounce) begin
            din = 1'b0;
            tick();
            din = 1'b1;
            tick();
        end
        din = 1'b0;
        repeat (6) tick();
    endtask

    task automatic load_b(input int v, input int exp);
        ld_b = 1'b1;
        lv_b = 3'(v);
        tick();
        ld_b = 1'b0;
        chk("b_load_mode", 32'(mode_b), exp);
        chk("b_load_step", 32'(step_b), 32'd0);
        cur_b = exp;
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; dir = 1'b0;
        ld_a = 1'b1; lv_a = 2'd2; ld_b = 1'b0; lv_b = '0;
        repeat (2) tick();
        chk("rst_a_mode", 32'(mode_a), 32'd0);
        chk("rst_a_sel", 32'(sel_a), 32'b0001);
        chk("rst_a_step", 32'(step_a), 32'd0);
        chk("rst_b_mode", 32'(mode_b), 32'd0);
        chk("rst_b_sel", 32'(sel_b), 32'b00001);
        rst = 1'b1; ld_a = 1'b0;
        tick();

        // Up: a wraps 3->0, b walks to its top mode 4
        press(1, 1, 1, 1, 0, 0, 0);
        press(2, 1, 2, 1, 0, 0, 0);
        press(3, 1, 3, 1, 0, 0, 0);
        press(0, 1, 4, 1, 0, 0, 0);

        // Down at 0: a wraps to 3, b saturates without a pulse
        load_b(0, 0);
        dir = 1'b1;
        press(3, 1, 0, 0, 0, 0, 0);
        load_b(2, 2);
        press(2, 1, 1, 1, 0, 0, 0);

        // Up at top: b saturates at 4
        load_b(4, 4);
        dir = 1'b0;
        press(3, 1, 4, 0, 0, 0, 0);

        // 3-cycle glitch is rejected
        din = 1'b1;
        repeat (3) tick();
        din = 1'b0;
        repeat (6) tick();
        chk("glitch_a", 32'(mode_a), 32'd3);
        chk("glitch_b", 32'(mode_b), 32'd4);

        // Release bounce gives no extra step
        dir = 1'b1;
        press(2, 1, 3, 1, 1, 0, 0);

        // Load coincident with accepted press wins, no pulse on b
        load_b(0, 0);
        dir = 1'b0;
        press(3, 1, 3, 0, 0, 1, 3);
        load_b(6, 3);
        load_b(5, 3);
        load_b(4, 4);

        // Reset while in RISE, press still held afterwards
        din = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("midrst_a_mode", 32'(mode_a), 32'd0);
        chk("midrst_b_mode", 32'(mode_b), 32'd0);
        chk("midrst_a_step", 32'(step_a), 32'd0);
        rst = 1'b1;
        cur_a = 0;
        cur_b = 0;
        press(1, 1, 1, 1, 0, 0, 0);

        repeat (3) tick();
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mode_sel_fsm.md
# mode_sel_fsm

Parametrised N-way mode selector that generalises the two-state toggle selector. A debounced press on `in` steps a mode register up or down through `N_MODES` states, with wrap-around or saturation. An optional synchronous load and a one-cycle step pulse are provided. It sits between a front-panel button and the datapath muxes, and drives both a binary mode index and a one-hot select bus.

## Interface
- `N_MODES`, 4: number of modes, legal 2..16.
- `DEB_CYCLES`, 4: consecutive equal samples needed to accept a level change on `in`, legal 1..255.
- `WRAP`, 1: 1 = wrap at the ends; 0 = saturate at 0 and N_MODES-1.
- `MODE_W`: derived, clog2(N_MODES), minimum 1. Not overridable.

Ports:
- `clk`  input  1  single clock; all logic is on its rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `in`  input  1  raw press input, active high, synchronous to `clk`.
- `dir`  input  1  step direction: 0 = up (+1), 1 = down (-1). Sampled at the accepting edge.
- `load`  input  1  synchronous load strobe.
- `load_val`  input  MODE_W  value to load.
- `mode`  output  MODE_W  current mode index, registered.
- `sel_out`  output  N_MODES  one-hot decode of `mode`, registered; bit `mode` is 1.
- `step_out`  output  1  one-cycle pulse, high for exactly the cycle after `mode` changed due to a press.

## Operation
Debounce FSM, four states, with counter `cnt` (8 bit):
- LOW: `in`=1 → if DEB_CYCLES=1, go to HIGH and accept a press; else go to RISE with cnt=1.
- RISE:
  - `in`=0 → LOW, cnt=0.
  - `in`=1 and cnt=DEB_CYCLES-1 → HIGH and accept a press.
  - otherwise cnt+1.
- HIGH: `in`=0 → FALL, cnt=1. If DEB_CYCLES=1, go directly to LOW instead.
- FALL:
  - `in`=1 → HIGH, cnt=0.
  - `in`=0 and cnt=DEB_CYCLES-1 → LOW.
  - otherwise cnt+1.
- Only the RISE→HIGH (or LOW→HIGH) transition produces a press. Release produces no action.

Mode update on an accepted press:
- up: mode=N_MODES-1 → 0 if WRAP=1, else hold. Otherwise mode+1.
- down: mode=0 → N_MODES-1 if WRAP=1, else hold. Otherwise mode-1.
- `step_out` goes high for one cycle only if `mode` actually changed. A saturated hold gives no pulse.

Load:
- `load`=1 with load_val < N_MODES: mode ← load_val.
- `load`=1 with load_val ≥ N_MODES: ignored, mode holds.
- Load has priority over a press at the same edge. That press is consumed: the FSM still goes to HIGH, but `step_out` stays 0.
- Load never asserts `step_out`.

Other rules:
- `sel_out` is always the one-hot form of `mode` and is never all-zero.
- Mode arithmetic is done in MODE_W+1 bits, then compared against N_MODES-1. Non-power-of-two N_MODES must never reach an illegal index.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM → LOW, cnt=0.
  - mode=0, sel_out=1 (bit 0), step_out=0.
  - Reset overrides load and press.
- Reset mid-press: the FSM restarts in LOW. A still-held `in` is treated as a new press after DEB_CYCLES samples.
- Press latency: with `in`=1 first sampled at edge E, `mode`/`sel_out` update at edge E+DEB_CYCLES-1 and `step_out` is high for the following cycle. With DEB_CYCLES=1, the update is at E.
- Load latency: `mode`/`sel_out` update at the edge where `load`=1 is sampled.
- A glitch shorter than DEB_CYCLES samples causes no state change beyond RISE/FALL and no output change.
- Minimum press-to-press interval: 2×DEB_CYCLES cycles (press, then release).

## Test plan
- Reset/default: N_MODES=4, DEB_CYCLES=4; assert `rst`=0 for 2 cycles → mode=0, sel_out=4'b0001, step_out=0.
- Wrap up: four clean presses (`in` high 6 cycles, low 6 cycles), `dir`=0 → mode 1,2,3,0. Each update occurs 3 edges after the first high sample, and each gives one step_out pulse.
- Saturate down: WRAP=0, mode=0, press with `dir`=1 → mode stays 0, step_out stays 0. Load 2, then press → mode=1 with one pulse.
- Glitch reject: `in` high for 3 cycles, then low → mode unchanged. Bounce 1-0-1 during release → no extra step.
- Load priority/illegal: N_MODES=5; load_val=3 with a press accepted on the same edge → mode=3, step_out=0. load_val=6 → mode unchanged.
- Reset mid-press: `rst`=0 while in RISE, then hold `in`=1 → mode=0 after reset. Exactly one step to 1 occurs DEB_CYCLES edges after reset release.
